// File: rtl/ahb_mem_arb.sv
// Two-master to one-slave AHB arbiter.
// Each transfer is arbitrated on its own, so bursts are never locked.
// A request that cannot be issued right away is parked in a per-master hold
// register. That master then sees HREADY low until its parked transfer is granted.
module ahb_mem_arb #(
  parameter int PRIO_FIXED = 0
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [1:0][1:0]  m_htrans,
  input  logic [1:0][31:0] m_haddr,
  input  logic [1:0]       m_hwrite,
  input  logic [1:0][2:0]  m_hsize,
  input  logic [1:0][2:0]  m_hburst,
  input  logic [1:0][3:0]  m_hprot,
  input  logic [1:0][63:0] m_hwdata,
  output logic [1:0]       m_hready,
  output logic [1:0]       m_hresp,
  output logic [1:0][63:0] m_hrdata,
  output logic             s_hsel,
  output logic             s_hwrite,
  output logic [1:0]       s_htrans,
  output logic [31:0]      s_haddr,
  output logic [2:0]       s_hsize,
  output logic [2:0]       s_hburst,
  output logic [3:0]       s_hprot,
  output logic [63:0]      s_hwdata,
  output logic             s_hready,
  input  logic             s_hreadyout,
  input  logic             s_hresp,
  input  logic [63:0]      s_hrdata
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
  } ctrl_t;

  ctrl_t [1:0] live_ctrl;
  ctrl_t [1:0] hold;
  ctrl_t       gnt_ctrl;
  ctrl_t       addr_q;
  ctrl_t       out_ctrl;
  logic  [1:0] pend;
  logic  [1:0] live_req;
  logic  [1:0] cand;
  logic        dph_valid;
  logic        dph_owner;
  logic        rr_last;
  logic        gnt_valid;
  logic        gnt_idx;

  // Master-side readiness, the live request qualification and the address-phase bundle
  always_comb begin
    m_hready  = '0;
    live_req  = '0;
    live_ctrl = '0;
    for (int i = 0; i < 2; i++) begin
      m_hready[i]  = ~pend[i] & (~dph_valid | (dph_owner != i[0]) | s_hreadyout);
      live_req[i]  = m_hready[i] & ((m_htrans[i] == HTRANS_NONSEQ) | (m_htrans[i] == HTRANS_SEQ));
      live_ctrl[i] = {m_haddr[i], m_hwrite[i], m_hsize[i], m_hburst[i], m_hprot[i]};
    end
  end

  assign cand = pend | live_req;

  // Pick a winner among the candidates. A parked transfer is presented from the hold register.
  always_comb begin
    gnt_valid = s_hreadyout & (|cand);
    gnt_idx   = 1'b0;
    if (cand == 2'b11) begin
      gnt_idx = (PRIO_FIXED != 0) ? 1'b0 : ~rr_last;
    end else begin
      gnt_idx = cand[1];
    end
    gnt_ctrl = pend[gnt_idx] ? hold[gnt_idx] : live_ctrl[gnt_idx];
  end

  // Slave request: the winner goes out in the same cycle; otherwise IDLE with the last address kept
  always_comb begin
    out_ctrl = gnt_valid ? gnt_ctrl : addr_q;
    s_hsel   = gnt_valid;
    s_htrans = gnt_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
    s_haddr  = out_ctrl.addr;
    s_hwrite = out_ctrl.write;
    s_hsize  = out_ctrl.size;
    s_hburst = out_ctrl.burst;
    s_hprot  = out_ctrl.prot;
  end

  // Data phase steering: write data and the error response follow the data-phase owner
  always_comb begin
    m_hresp = '0;
    if (dph_valid) begin
      m_hresp[dph_owner] = s_hresp;
    end
  end

  assign s_hwdata    = m_hwdata[dph_owner];
  assign s_hready    = s_hreadyout;
  assign m_hrdata[0] = s_hrdata;
  assign m_hrdata[1] = s_hrdata;

  // Grant bookkeeping: last presented address, round-robin pointer and data-phase owner
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q    <= '0;
      rr_last   <= 1'b1;
      dph_valid <= 1'b0;
      dph_owner <= 1'b0;
    end else if (gnt_valid) begin
      addr_q    <= gnt_ctrl;
      rr_last   <= gnt_idx;
      dph_valid <= 1'b1;
      dph_owner <= gnt_idx;
    end else if (s_hreadyout) begin
      dph_valid <= 1'b0;
    end
  end

  // Park requests that lost arbitration or arrived during a wait state; release them when they are granted
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend <= '0;
      hold <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (gnt_valid && (gnt_idx == i[0])) begin
          pend[i] <= 1'b0;
        end else if (live_req[i]) begin
          pend[i] <= 1'b1;
          hold[i] <= live_ctrl[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_mem_arb.sv
// Testbench for ahb_mem_arb.
// A round-robin instance is checked against a transaction-level reference model.
// A fixed-priority instance, sharing the same inputs, is checked against directed expectations.
module tb_ahb_mem_arb;

  logic             HCLK;
  logic             HRESETn;
  logic [1:0][1:0]  m_htrans;
  logic [1:0][31:0] m_haddr;
  logic [1:0]       m_hwrite;
  logic [1:0][2:0]  m_hsize;
  logic [1:0][2:0]  m_hburst;
  logic [1:0][3:0]  m_hprot;
  logic [1:0][63:0] m_hwdata;
  logic [1:0]       m_hready, m_hresp;
  logic [1:0][63:0] m_hrdata;
  logic             s_hsel, s_hwrite, s_hready;
  logic [1:0]       s_htrans;
  logic [31:0]      s_haddr;
  logic [2:0]       s_hsize, s_hburst;
  logic [3:0]       s_hprot;
  logic [63:0]      s_hwdata;
  logic             s_hreadyout, s_hresp;
  logic [63:0]      s_hrdata;

  logic [1:0]       fx_m_hready, fx_m_hresp;
  logic [1:0][63:0] fx_m_hrdata;
  logic             fx_s_hsel, fx_s_hwrite, fx_s_hready;
  logic [1:0]       fx_s_htrans;
  logic [31:0]      fx_s_haddr;
  logic [2:0]       fx_s_hsize, fx_s_hburst;
  logic [3:0]       fx_s_hprot;
  logic [63:0]      fx_s_hwdata;

  int checks = 0;
  int failures = 0;

  ahb_mem_arb #(.PRIO_FIXED(0)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .m_htrans(m_htrans), .m_haddr(m_haddr), .m_hwrite(m_hwrite), .m_hsize(m_hsize),
    .m_hburst(m_hburst), .m_hprot(m_hprot), .m_hwdata(m_hwdata),
    .m_hready(m_hready), .m_hresp(m_hresp), .m_hrdata(m_hrdata),
    .s_hsel(s_hsel), .s_hwrite(s_hwrite), .s_htrans(s_htrans), .s_haddr(s_haddr),
    .s_hsize(s_hsize), .s_hburst(s_hburst), .s_hprot(s_hprot), .s_hwdata(s_hwdata),
    .s_hready(s_hready), .s_hreadyout(s_hreadyout), .s_hresp(s_hresp), .s_hrdata(s_hrdata)
  );

  ahb_mem_arb #(.PRIO_FIXED(1)) dut_fx (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .m_htrans(m_htrans), .m_haddr(m_haddr), .m_hwrite(m_hwrite), .m_hsize(m_hsize),
    .m_hburst(m_hburst), .m_hprot(m_hprot), .m_hwdata(m_hwdata),
    .m_hready(fx_m_hready), .m_hresp(fx_m_hresp), .m_hrdata(fx_m_hrdata),
    .s_hsel(fx_s_hsel), .s_hwrite(fx_s_hwrite), .s_htrans(fx_s_htrans), .s_haddr(fx_s_haddr),
    .s_hsize(fx_s_hsize), .s_hburst(fx_s_hburst), .s_hprot(fx_s_hprot), .s_hwdata(fx_s_hwdata),
    .s_hready(fx_s_hready), .s_hreadyout(s_hreadyout), .s_hresp(s_hresp), .s_hrdata(s_hrdata)
  );

  // Free-running clock
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Reference model: one transfer record per master, plus who went last and who owns the data phase
  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
  } xfer_t;

  bit    mdl_pend [2];
  xfer_t mdl_held [2];
  int    mdl_last;
  bit    mdl_dph;
  int    mdl_dph_who;
  xfer_t mdl_shown;

  logic [1:0]  exp_mready;
  logic [1:0]  exp_mresp;
  bit          exp_live [2];
  xfer_t       exp_livex [2];
  bit          exp_grant;
  int          exp_win;
  xfer_t       exp_x;
  logic [63:0] exp_wdata;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mdl_pend[i] = 0;
      mdl_held[i] = '{32'h0, 1'b0, 3'h0, 3'h0, 4'h0};
    end
    mdl_last    = 1;
    mdl_dph     = 0;
    mdl_dph_who = 0;
    mdl_shown   = '{32'h0, 1'b0, 3'h0, 3'h0, 4'h0};
  endtask

  task automatic model_eval();
    bit wants [2];
    for (int i = 0; i < 2; i++) begin
      exp_mready[i] = !mdl_pend[i] && !(mdl_dph && mdl_dph_who == i && !s_hreadyout);
      exp_livex[i]  = '{m_haddr[i], m_hwrite[i], m_hsize[i], m_hburst[i], m_hprot[i]};
      exp_live[i]   = exp_mready[i] && (m_htrans[i] >= 2'd2);
      wants[i]      = mdl_pend[i] || exp_live[i];
    end
    exp_grant = s_hreadyout && (wants[0] || wants[1]);
    if (wants[0] && wants[1]) exp_win = 1 - mdl_last;
    else exp_win = wants[1] ? 1 : 0;
    if (exp_grant) exp_x = mdl_pend[exp_win] ? mdl_held[exp_win] : exp_livex[exp_win];
    else exp_x = mdl_shown;
    exp_wdata = m_hwdata[mdl_dph_who];
    exp_mresp = 2'b00;
    if (mdl_dph) exp_mresp[mdl_dph_who] = s_hresp;
  endtask

  task automatic model_advance();
    if (exp_grant) begin
      mdl_last          = exp_win;
      mdl_dph           = 1;
      mdl_dph_who       = exp_win;
      mdl_shown         = exp_x;
      mdl_pend[exp_win] = 0;
    end else if (s_hreadyout) begin
      mdl_dph = 0;
    end
    for (int i = 0; i < 2; i++) begin
      if (exp_live[i] && !(exp_grant && exp_win == i)) begin
        mdl_pend[i] = 1;
        mdl_held[i] = exp_livex[i];
      end
    end
  endtask

  task automatic idle_inputs();
    m_htrans    = '0;
    m_haddr     = '0;
    m_hwrite    = '0;
    m_hsize     = '0;
    m_hburst    = '0;
    m_hprot     = '0;
    m_hwdata    = '0;
    s_hreadyout = 1'b1;
    s_hresp     = 1'b0;
    s_hrdata    = '0;
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge HCLK);
    model_advance();
    @(negedge HCLK);
  endtask

  task automatic do_reset();
    idle_inputs();
    HRESETn = 1'b0;
    model_reset();
    @(negedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    HRESETn = 1'b0;
    model_reset();
    @(negedge HCLK);
    #1;
    checks++; if (s_hsel !== 1'b0) begin failures++; $display("[TB] FAIL reset_hsel: got %0b want 0", s_hsel); end
    checks++; if (s_htrans !== 2'b00) begin failures++; $display("[TB] FAIL reset_htrans: got %0b want 00", s_htrans); end
    checks++; if (s_haddr !== 32'h0) begin failures++; $display("[TB] FAIL reset_haddr: got %h want 0", s_haddr); end
    checks++; if (m_hready !== 2'b11) begin failures++; $display("[TB] FAIL reset_mready: got %b want 11", m_hready); end
    checks++; if (m_hresp !== 2'b00) begin failures++; $display("[TB] FAIL reset_mresp: got %b want 00", m_hresp); end
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  task automatic test_single_master();
    logic [63:0] rd;
    do_reset();
    m_htrans[0] = 2'b10; m_haddr[0] = 32'h1000; m_hwrite[0] = 1'b0;
    settle();
    checks++; if (s_haddr !== 32'h1000) begin failures++; $display("[TB] FAIL single_haddr: got %h want 1000", s_haddr); end
    checks++; if (s_hsel !== 1'b1 || s_htrans !== 2'b10) begin failures++; $display("[TB] FAIL single_sel: got %0b/%b want 1/10", s_hsel, s_htrans); end
    checks++; if (m_hready[0] !== 1'b1) begin failures++; $display("[TB] FAIL single_ready: got %0b want 1", m_hready[0]); end
    tick();
    m_htrans[0] = 2'b00;
    rd = {$urandom, $urandom};
    s_hrdata = rd;
    settle();
    checks++; if (m_hrdata[0] !== rd) begin failures++; $display("[TB] FAIL single_rdata: got %h want %h", m_hrdata[0], rd); end
    checks++; if (s_hsel !== 1'b0 || s_haddr !== 32'h1000) begin failures++; $display("[TB] FAIL single_idle: got %0b/%h want 0/1000", s_hsel, s_haddr); end
    tick();
  endtask

  task automatic test_collision();
    logic [63:0] wd;
    do_reset();
    m_htrans[0] = 2'b10; m_haddr[0] = 32'h2000; m_hwrite[0] = 1'b1;
    m_htrans[1] = 2'b10; m_haddr[1] = 32'h3000; m_hwrite[1] = 1'b0;
    settle();
    checks++; if (s_haddr !== 32'h2000 || s_hwrite !== 1'b1) begin failures++; $display("[TB] FAIL coll_first: got %h/%0b want 2000/1", s_haddr, s_hwrite); end
    tick();
    m_htrans = '0;
    wd = {$urandom, $urandom};
    m_hwdata[0] = wd;
    settle();
    checks++; if (m_hready[1] !== 1'b0) begin failures++; $display("[TB] FAIL coll_m1_wait: got %0b want 0", m_hready[1]); end
    checks++; if (s_haddr !== 32'h3000 || s_hwrite !== 1'b0) begin failures++; $display("[TB] FAIL coll_second: got %h/%0b want 3000/0", s_haddr, s_hwrite); end
    checks++; if (s_hwdata !== wd) begin failures++; $display("[TB] FAIL coll_wdata: got %h want %h", s_hwdata, wd); end
    tick();
    settle();
    checks++; if (m_hready[1] !== 1'b1 || s_hsel !== 1'b0) begin failures++; $display("[TB] FAIL coll_done: got %0b/%0b want 1/0", m_hready[1], s_hsel); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [31:0] want;
    do_reset();
    m_htrans[0] = 2'b10; m_haddr[0] = 32'hA000;
    m_htrans[1] = 2'b10; m_haddr[1] = 32'hB000;
    for (int k = 0; k < 6; k++) begin
      settle();
      want = (k % 2 == 0) ? 32'hA000 : 32'hB000;
      checks++; if (s_haddr !== want || s_hsel !== 1'b1) begin failures++; $display("[TB] FAIL rr_grant%0d: got %h/%0b want %h/1", k, s_haddr, s_hsel, want); end
      tick();
    end
    idle_inputs();
    settle();
    tick();
  endtask

  task automatic test_slave_wait();
    do_reset();
    m_htrans[0] = 2'b10; m_haddr[0] = 32'h4000;
    settle();
    checks++; if (s_haddr !== 32'h4000) begin failures++; $display("[TB] FAIL wait_grant0: got %h want 4000", s_haddr); end
    tick();
    m_htrans[0] = 2'b00;
    s_hreadyout = 1'b0;
    m_htrans[1] = 2'b10; m_haddr[1] = 32'h5000; m_hwrite[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      checks++; if (m_hready[0] !== 1'b0) begin failures++; $display("[TB] FAIL wait_owner%0d: got %0b want 0", k, m_hready[0]); end
      checks++; if (m_hready[1] !== ((k == 0) ? 1'b1 : 1'b0)) begin failures++; $display("[TB] FAIL wait_other%0d: got %0b want %0b", k, m_hready[1], (k == 0)); end
      checks++; if (s_hsel !== 1'b0 || s_haddr !== 32'h4000) begin failures++; $display("[TB] FAIL wait_frozen%0d: got %0b/%h want 0/4000", k, s_hsel, s_haddr); end
      tick();
      m_htrans[1] = 2'b00;
    end
    s_hreadyout = 1'b1;
    settle();
    checks++; if (m_hready[0] !== 1'b1) begin failures++; $display("[TB] FAIL wait_release: got %0b want 1", m_hready[0]); end
    checks++; if (s_hsel !== 1'b1 || s_haddr !== 32'h5000 || s_hwrite !== 1'b1) begin failures++; $display("[TB] FAIL wait_held_issue: got %0b/%h/%0b want 1/5000/1", s_hsel, s_haddr, s_hwrite); end
    tick();
  endtask

  task automatic test_error();
    do_reset();
    m_htrans[1] = 2'b10; m_haddr[1] = 32'h6000;
    settle();
    tick();
    m_htrans[1] = 2'b00;
    s_hresp = 1'b1;
    settle();
    checks++; if (m_hresp !== 2'b10) begin failures++; $display("[TB] FAIL err_resp: got %b want 10", m_hresp); end
    tick();
    s_hresp = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_htrans[0] = 2'b10; m_haddr[0] = 32'h7000;
    m_htrans[1] = 2'b10; m_haddr[1] = 32'h8000;
    settle();
    tick();
    idle_inputs();
    HRESETn = 1'b0;
    model_reset();
    #1;
    checks++; if (m_hready !== 2'b11) begin failures++; $display("[TB] FAIL rstmid_ready: got %b want 11", m_hready); end
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      checks++; if (s_hsel !== 1'b0 || m_hresp !== 2'b00) begin failures++; $display("[TB] FAIL rstmid_quiet%0d: got %0b/%b want 0/00", k, s_hsel, m_hresp); end
      tick();
    end
  endtask

  task automatic test_fixed_prio();
    do_reset();
    m_htrans[0] = 2'b10; m_haddr[0] = 32'hC000;
    m_htrans[1] = 2'b10; m_haddr[1] = 32'hD000;
    for (int k = 0; k < 5; k++) begin
      settle();
      checks++; if (fx_s_haddr !== 32'hC000 || fx_s_hsel !== 1'b1) begin failures++; $display("[TB] FAIL fx_m0_%0d: got %h/%0b want C000/1", k, fx_s_haddr, fx_s_hsel); end
      checks++; if (fx_m_hready[1] !== ((k == 0) ? 1'b1 : 1'b0)) begin failures++; $display("[TB] FAIL fx_m1wait%0d: got %0b want %0b", k, fx_m_hready[1], (k == 0)); end
      tick();
    end
    m_htrans = '0;
    settle();
    checks++; if (fx_s_haddr !== 32'hD000 || fx_s_hsel !== 1'b1) begin failures++; $display("[TB] FAIL fx_m1_issue: got %h/%0b want D000/1", fx_s_haddr, fx_s_hsel); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++) begin
        m_htrans[i] = 2'($urandom_range(0, 3));
        m_haddr[i]  = $urandom;
        m_hwrite[i] = 1'($urandom);
        m_hsize[i]  = 3'($urandom);
        m_hburst[i] = 3'($urandom);
        m_hprot[i]  = 4'($urandom);
        m_hwdata[i] = {$urandom, $urandom};
      end
      s_hreadyout = ($urandom_range(0, 3) != 0);
      s_hresp     = ($urandom_range(0, 7) == 0);
      s_hrdata    = {$urandom, $urandom};
      settle();
      checks++; if (m_hready !== exp_mready) begin failures++; $display("[TB] FAIL rnd_ready@%0d: got %b want %b", k, m_hready, exp_mready); end
      checks++; if (s_hsel !== exp_grant || s_htrans !== (exp_grant ? 2'b10 : 2'b00)) begin failures++; $display("[TB] FAIL rnd_sel@%0d: got %0b/%b want %0b", k, s_hsel, s_htrans, exp_grant); end
      checks++; if ({s_haddr, s_hwrite, s_hsize, s_hburst, s_hprot} !== {exp_x.addr, exp_x.write, exp_x.size, exp_x.burst, exp_x.prot}) begin failures++; $display("[TB] FAIL rnd_ctrl@%0d: got %h/%0b/%h/%h/%h want %h/%0b/%h/%h/%h", k, s_haddr, s_hwrite, s_hsize, s_hburst, s_hprot, exp_x.addr, exp_x.write, exp_x.size, exp_x.burst, exp_x.prot); end
      checks++; if (s_hwdata !== exp_wdata) begin failures++; $display("[TB] FAIL rnd_wdata@%0d: got %h want %h", k, s_hwdata, exp_wdata); end
      checks++; if (m_hresp !== exp_mresp) begin failures++; $display("[TB] FAIL rnd_resp@%0d: got %b want %b", k, m_hresp, exp_mresp); end
      checks++; if (m_hrdata[0] !== s_hrdata || m_hrdata[1] !== s_hrdata || s_hready !== s_hreadyout) begin failures++; $display("[TB] FAIL rnd_bcast@%0d: got %h/%h/%0b want %h/%0b", k, m_hrdata[0], m_hrdata[1], s_hready, s_hrdata, s_hreadyout); end
      tick();
    end
  endtask

  // Test sequence
  initial begin
    idle_inputs();
    HRESETn = 1'b0;
    test_reset();
    test_single_master();
    test_collision();
    test_round_robin();
    test_slave_wait();
    test_error();
    test_reset_mid();
    test_fixed_prio();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
